// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue
//  Purpose  : Command FIFO plus issue sequencer for an external combinational
//             ALU. Commands are queued, issued one at a time, the ALU result
//             is captured after one execute cycle and held until consumed.
//  Revision : 1.0  initial release
// ============================================================================
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_op,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [3:0]               in_tag,
  output logic [3:0]               alu_op,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  input  logic [31:0]              alu_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_y,
  output logic [3:0]               out_tag,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  logic [3:0]    mem_op_q  [DEPTH];
  logic [31:0]   mem_a_q   [DEPTH];
  logic [31:0]   mem_b_q   [DEPTH];
  logic [3:0]    mem_tag_q [DEPTH];

  logic [3:0]    alu_op_q;
  logic [31:0]   alu_a_q, alu_b_q;
  logic [3:0]    tag_q;
  logic [31:0]   out_y_q;
  logic [3:0]    out_tag_q;
  logic          out_err_q;

  logic          push, pop, div_zero;

  // Ready depends only on the registered occupancy, so no combinational path
  // from in_valid; reset clears the count so ready rises asynchronously.
  assign in_ready = (cnt_q != C_FULL);
  assign push     = in_valid && in_ready;
  assign div_zero = ((alu_op_q == 4'd3) || (alu_op_q == 4'd4) || (alu_op_q == 4'd5))
                    && (alu_b_q == 32'd0);

  // Issue sequencer: decides the next state and whether the head is popped.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_HOLD;
      S_HOLD: begin
        if (out_ready) begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = S_EXEC;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op_q[wptr_q]  <= in_op;
      mem_a_q[wptr_q]   <= in_a;
      mem_b_q[wptr_q]   <= in_b;
      mem_tag_q[wptr_q] <= in_tag;
    end
  end

  // State, pointers, occupancy, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      alu_op_q  <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      tag_q     <= '0;
      out_y_q   <= '0;
      out_tag_q <= '0;
      out_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
      // Operands change only when a command is popped.
      if (pop) begin
        alu_op_q <= mem_op_q[rptr_q];
        alu_a_q  <= mem_a_q[rptr_q];
        alu_b_q  <= mem_b_q[rptr_q];
        tag_q    <= mem_tag_q[rptr_q];
      end
      // Result captured at the end of the single execute cycle.
      if (state_q == S_EXEC) begin
        out_y_q   <= div_zero ? 32'd0 : alu_y;
        out_err_q <= div_zero;
        out_tag_q <= tag_q;
      end
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign out_valid = (state_q == S_HOLD);
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;
  assign pending   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue
//  Purpose  : Directed self-checking bench for alu_issue with an attached
//             combinational ALU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [2:0]  pending;

  int total = 0;
  int bad   = 0;

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_tag(out_tag), .out_err(out_err), .pending(pending)
  );

  always #5 clk = ~clk;

  // Downstream ALU; a zero divisor yields garbage the DUT must suppress.
  always_comb begin
    alu_y = alu_a ^ alu_b;
    case (alu_op)
      4'd0: alu_y = alu_a + alu_b;
      4'd1: alu_y = alu_a - alu_b;
      4'd2: alu_y = alu_a * alu_b;
      4'd3: alu_y = (alu_b == 0) ? 32'hDEAD_BEEF : $signed(alu_a) / $signed(alu_b);
      4'd4: alu_y = (alu_b == 0) ? 32'hDEAD_BEEF : $signed(alu_a) % $signed(alu_b);
      4'd5: alu_y = (alu_b == 0) ? 32'hDEAD_BEEF : alu_a / alu_b;
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] tag);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    while (!in_ready && n < 50) begin tick(); n++; end
    total++;
    if (n >= 50) begin bad++; $display("FAIL push_timeout: in_ready got %0b required 1", in_ready); end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] ey,
                             input logic [3:0] et, input logic ee);
    int n = 0;
    while (!out_valid && n < 30) begin tick(); n++; end
    total++;
    if (n >= 30) begin bad++; $display("FAIL %s_timeout: out_valid got 0 required 1", name); end
    total++;
    if (out_y !== ey) begin bad++; $display("FAIL %s_y: got %0h required %0h", name, out_y, ey); end
    total++;
    if (out_tag !== et) begin bad++; $display("FAIL %s_tag: got %0d required %0d", name, out_tag, et); end
    total++;
    if (out_err !== ee) begin bad++; $display("FAIL %s_err: got %0b required %0b", name, out_err, ee); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  // Consume n results expecting tags 0..n-1 with y = tag + 10.
  task automatic drain(input string name, input int n, input bit chk_gap);
    int k = 0, cyc = 0, last = 0;
    out_ready = 1'b1;
    while (k < n && cyc < 200) begin
      if (out_valid) begin
        total++;
        if (out_tag !== 4'(k)) begin bad++; $display("FAIL %s_tag: got %0d required %0d", name, out_tag, k); end
        total++;
        if (out_y !== 32'(k + 10) || out_err !== 1'b0) begin
          bad++; $display("FAIL %s_y: got %0d/%0b required %0d/0", name, out_y, out_err, k + 10);
        end
        if (chk_gap && k > 0) begin
          total++;
          if (cyc - last != 2) begin bad++; $display("FAIL %s_gap: got %0d required 2", name, cyc - last); end
        end
        last = cyc;
        k++;
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    total++;
    if (k != n) begin bad++; $display("FAIL %s_count: got %0d required %0d", name, k, n); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    #3;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b required 1", in_ready); end
    total++;
    if (out_valid !== 1'b0 || pending !== 3'd0) begin
      bad++; $display("FAIL rst_state: got valid=%0b pending=%0d required 0/0", out_valid, pending);
    end
    total++;
    if (out_y !== 32'd0 || out_tag !== 4'd0 || out_err !== 1'b0) begin
      bad++; $display("FAIL rst_out: got %0h/%0d/%0b required 0/0/0", out_y, out_tag, out_err);
    end
    total++;
    if (alu_op !== 4'd0 || alu_a !== 32'd0 || alu_b !== 32'd0) begin
      bad++; $display("FAIL rst_alu: got %0d/%0h/%0h required 0/0/0", alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  task automatic test_single_add();
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd5; in_b = 32'd7; in_tag = 4'd3;
    tick();
    in_valid = 1'b0;
    total++;
    if (pending !== 3'd1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL add_n0: got pending=%0d valid=%0b required 1/0", pending, out_valid);
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || pending !== 3'd0) begin
      bad++; $display("FAIL add_n1: got valid=%0b pending=%0d required 0/0", out_valid, pending);
    end
    total++;
    if (alu_op !== 4'd0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin
      bad++; $display("FAIL add_issue: got %0d/%0d/%0d required 0/5/7", alu_op, alu_a, alu_b);
    end
    tick();
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL add_n2_valid: got %0b required 1", out_valid); end
    total++;
    if (out_y !== 32'd12 || out_tag !== 4'd3 || out_err !== 1'b0) begin
      bad++; $display("FAIL add_result: got %0d/%0d/%0b required 12/3/0", out_y, out_tag, out_err);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL add_done: got %0b required 0", out_valid); end
    tick();
    total++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
      bad++; $display("FAIL idle_hold: got %0d/%0d required 5/7", alu_a, alu_b);
    end
  endtask

  task automatic test_div_zero();
    push(4'd3, 32'd100, 32'd0, 4'd1);
    wait_result("div0", 32'd0, 4'd1, 1'b1);
    push(4'd3, 32'd100, 32'd7, 4'd2);
    wait_result("div7", 32'd14, 4'd2, 1'b0);
    push(4'd4, 32'hFFFF_FFF9, 32'd0, 4'd4);
    wait_result("mod0", 32'd0, 4'd4, 1'b1);
    push(4'd5, 32'd9, 32'd0, 4'd6);
    wait_result("udiv0", 32'd0, 4'd6, 1'b1);
    push(4'd1, 32'd3, 32'd5, 4'd5);
    wait_result("sub", 32'hFFFF_FFFE, 4'd5, 1'b0);
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(4'd0, 32'(i), 32'd10, 4'(i));
    total++;
    if (pending !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full: got pending=%0d ready=%0b required 4/0", pending, in_ready);
    end
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd99; in_b = 32'd1; in_tag = 4'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (pending !== 3'd4 || in_ready !== 1'b0) begin
        bad++; $display("FAIL fill_wait: got pending=%0d ready=%0b required 4/0", pending, in_ready);
      end
    end
    in_valid = 1'b0;
    drain("fill", DEPTH + 1, 1'b0);
  endtask

  task automatic test_backpressure();
    int n = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'd0, 32'(i), 32'd10, 4'(i));
    while (!out_valid && n < 30) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_tag !== 4'd0 || out_y !== 32'd10) begin
        bad++; $display("FAIL bp_hold: got %0b/%0d/%0d required 1/0/10", out_valid, out_tag, out_y);
      end
      tick();
    end
    drain("bp", 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 8; i++) push(4'd0, 32'(i), 32'd10, 4'(i));
      end
      drain("stream", 8, 1'b1);
    join
  endtask

  task automatic test_reset_mid_exec();
    int seen = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(4'd0, 32'(i), 32'd10, 4'(i));
    total++;
    if (out_valid !== 1'b1 || pending !== 3'd2) begin
      bad++; $display("FAIL mid_pre: got valid=%0b pending=%0d required 1/2", out_valid, pending);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd3; in_b = 32'd10; in_tag = 4'd3;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || pending !== 3'd2 || alu_a !== 32'd1) begin
      bad++; $display("FAIL mid_exec: got valid=%0b pending=%0d a=%0d required 0/2/1", out_valid, pending, alu_a);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || pending !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_rst: got valid=%0b pending=%0d ready=%0b required 0/0/1", out_valid, pending, in_ready);
    end
    total++;
    if (out_tag !== 4'd0 || alu_a !== 32'd0) begin
      bad++; $display("FAIL mid_rst_regs: got tag=%0d a=%0d required 0/0", out_tag, alu_a);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid || pending != 0) seen++;
    end
    total++;
    if (seen != 0) begin bad++; $display("FAIL mid_stale: got %0d active cycles required 0", seen); end
    push(4'd2, 32'd6, 32'd7, 4'd9);
    wait_result("post_rst", 32'd42, 4'd9, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_div_zero();
    test_fill();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
